// File: rtl/draw_bg_scroll_if.sv
// VGA pixel bundle between draw stages: timing counters, syncs, blanks, rgb.
// Modports: vga_out drives the bundle, vga_in consumes it.
interface vga_if;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport vga_out (
        output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );
    modport vga_in (
        input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
    );
endinterface

// File: rtl/draw_bg_scroll.sv
// Scaled, scrolled, wrap-around background renderer composited with overlays.
// Ports: clk/rst (sync, active-high); timing in (h/v count, sync, blank);
//   bg_addr -> ROM, rgb_background <- ROM (ROM_LAT later); scroll_we/x/y
//   shadow writes, latched at vblank rise; bg_front priority select;
//   layer_on/layer_rgb overlays; vga_out delayed timing + composited rgb.
// Optional: DRAW_BG_DIM_EN adds dim_shift[1:0], a per-frame channel dimmer.
module draw_bg_scroll #(
    parameter int          SCALE_SHIFT = 2,
    parameter int          BG_W        = 256,
    parameter int          BG_H        = 256,
    parameter int          ADDR_W      = 20,
    parameter int          ROM_LAT     = 1,
    parameter int          NLAYERS     = 2,
    parameter logic [11:0] KEY_COLOR   = 12'h000,
    localparam int         XW          = $clog2(BG_W),
    localparam int         YW          = $clog2(BG_H)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [10:0]           vcount_in,
    input  logic                  vsync_in,
    input  logic                  vblnk_in,
    input  logic [10:0]           hcount_in,
    input  logic                  hsync_in,
    input  logic                  hblnk_in,
    output logic [ADDR_W-1:0]     bg_addr,
    input  logic [11:0]           rgb_background,
    input  logic                  scroll_we,
    input  logic [XW-1:0]         scroll_x,
    input  logic [YW-1:0]         scroll_y,
    input  logic                  bg_front,
    input  logic [NLAYERS-1:0]    layer_on,
    input  logic [12*NLAYERS-1:0] layer_rgb,
`ifdef DRAW_BG_DIM_EN
    input  logic [1:0]            dim_shift,
`endif
    vga_if.vga_out                vga_out
);

    localparam int D = ROM_LAT + 1;

    typedef struct packed {
        logic [10:0]           hc;
        logic [10:0]           vc;
        logic                  hs;
        logic                  vs;
        logic                  hb;
        logic                  vb;
        logic [NLAYERS-1:0]    on;
        logic [12*NLAYERS-1:0] rgb;
    } dly_t;

    logic            r_vblnk_prev;
    logic [XW-1:0]   r_shd_x;
    logic [YW-1:0]   r_shd_y;
    logic [XW-1:0]   r_act_x;
    logic [YW-1:0]   r_act_y;
    logic [ADDR_W-1:0] r_addr;
    dly_t            r_dly [D];

    logic            w_vb_rise;
    logic [XW-1:0]   w_sx;
    logic [YW-1:0]   w_sy;
    dly_t            w_in;
    dly_t            w_d;
    logic [11:0]     w_lsel;
    logic            w_lany;
    logic            w_bgok;
    logic [11:0]     w_pix;
    logic [11:0]     w_out;

    assign w_vb_rise = vblnk_in & ~r_vblnk_prev;

    // Scroll: shadow takes every write; active only at vblank rise, with a
    // same-cycle write passed straight through so it is not lost a frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vblnk_prev <= 1'b0;
            r_shd_x      <= '0;
            r_shd_y      <= '0;
            r_act_x      <= '0;
            r_act_y      <= '0;
        end else begin
            r_vblnk_prev <= vblnk_in;
            if (scroll_we) begin
                r_shd_x <= scroll_x;
                r_shd_y <= scroll_y;
            end
            if (w_vb_rise) begin
                r_act_x <= scroll_we ? scroll_x : r_shd_x;
                r_act_y <= scroll_we ? scroll_y : r_shd_y;
            end
        end
    end

    // Truncating add gives the wrap; power-of-two width makes {sy,sx}
    // equal to sy*BG_W+sx.
    assign w_sx = hcount_in[SCALE_SHIFT +: XW] + r_act_x;
    assign w_sy = vcount_in[SCALE_SHIFT +: YW] + r_act_y;

    always_ff @(posedge clk) begin
        if (rst) r_addr <= '0;
        else     r_addr <= ADDR_W'({w_sy, w_sx});
    end

    assign bg_addr = r_addr;

    assign w_in = '{hc: hcount_in, vc: vcount_in, hs: hsync_in,
                    vs: vsync_in, hb: hblnk_in, vb: vblnk_in,
                    on: layer_on, rgb: layer_rgb};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < D; k++) r_dly[k] <= '0;
        end else begin
            r_dly[0] <= w_in;
            for (int k = 1; k < D; k++) r_dly[k] <= r_dly[k-1];
        end
    end

    assign w_d = r_dly[D-1];

    // Downward scan so the lowest-index active layer wins.
    always_comb begin
        w_lsel = '0;
        for (int i = NLAYERS - 1; i >= 0; i--) begin
            if (w_d.on[i]) w_lsel = w_d.rgb[12*i +: 12];
        end
    end

    assign w_lany = |w_d.on;
    assign w_bgok = (rgb_background != KEY_COLOR);

    always_comb begin
        w_pix = '0;
        if (w_d.hb || w_d.vb) begin
            w_pix = '0;
        end else if (bg_front) begin
            if (w_bgok)      w_pix = rgb_background;
            else if (w_lany) w_pix = w_lsel;
        end else begin
            if (w_lany)      w_pix = w_lsel;
            else if (w_bgok) w_pix = rgb_background;
        end
    end

`ifdef DRAW_BG_DIM_EN
    logic [1:0] r_dim;

    always_ff @(posedge clk) begin
        if (rst)            r_dim <= '0;
        else if (w_vb_rise) r_dim <= dim_shift;
    end

    assign w_out = {w_pix[11:8] >> r_dim,
                    w_pix[7:4]  >> r_dim,
                    w_pix[3:0]  >> r_dim};
`else
    assign w_out = w_pix;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_out.vcount <= '0;
            vga_out.vsync  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.hcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.vcount <= w_d.vc;
            vga_out.vsync  <= w_d.vs;
            vga_out.vblnk  <= w_d.vb;
            vga_out.hcount <= w_d.hc;
            vga_out.hsync  <= w_d.hs;
            vga_out.hblnk  <= w_d.hb;
            vga_out.rgb    <= w_out;
        end
    end

endmodule
